// File: rtl/parking_ctrl_if.sv
// Sensor, password and indicator signals shared between the parking
// controller (slave) and whatever drives the gate sensors (master).
interface parking_ctrl_if #(
    parameter int PW_W  = 4,
    parameter int CNT_W = 4
);
    logic             car_in;
    logic             car_out;
    logic             pw_valid;
    logic [PW_W-1:0]  pw_data;
    logic             green_led;
    logic             red_led;
    logic             gate_open;
    logic             locked;
    logic             full;
    logic [CNT_W-1:0] count;

    modport master (
        output car_in, car_out, pw_valid, pw_data,
        input  green_led, red_led, gate_open, locked, full, count
    );

    modport slave (
        input  car_in, car_out, pw_valid, pw_data,
        output green_led, red_led, gate_open, locked, full, count
    );
endinterface

// File: rtl/parking_ctrl.sv
// Parking lot entry controller: password-gated entry with retry lockout,
// timed gate opening and an occupancy counter fed by entry and exit events.
module parking_ctrl #(
    parameter int              CAPACITY    = 8,
    parameter int              PW_W        = 4,
    parameter logic [PW_W-1:0] PASSWORD    = 4'hA,
    parameter int              MAX_TRIES   = 3,
    parameter int              GATE_CYCLES = 8,
    parameter int              LOCK_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    parking_ctrl_if.slave bus
);
    localparam int CNT_W   = $clog2(CAPACITY + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);
    localparam logic [TRY_W-1:0] TRIES_V = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] GATE_V  = TMR_W'(GATE_CYCLES);
    localparam logic [TMR_W-1:0] LOCK_V  = TMR_W'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_PW = 3'd1,
        WRONG   = 3'd2,
        OPEN    = 3'd3,
        LOCK    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             fullNow;
    logic             openExit;
    logic             incCount;
    logic             decCount;

    assign fullNow = (count_q == CAP_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tries_q <= '0;
            timer_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    // One down-counter serves both the gate-open and lockout durations,
    // since the two states are mutually exclusive.
    always_comb begin
        state_d  = state_q;
        tries_d  = tries_q;
        timer_d  = timer_q;
        openExit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.car_in && !fullNow) begin
                    state_d = WAIT_PW;
                    tries_d = '0;
                end
            end
            WAIT_PW, WRONG: begin
                if (bus.pw_valid) begin
                    if (bus.pw_data == PASSWORD) begin
                        state_d = OPEN;
                        timer_d = GATE_V;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                        if (tries_d == TRIES_V) begin
                            state_d = LOCK;
                            timer_d = LOCK_V;
                        end else begin
                            state_d = WRONG;
                        end
                    end
                end
            end
            OPEN: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d  = IDLE;
                    timer_d  = '0;
                    openExit = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            LOCK: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = IDLE;
                    tries_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tries_d = '0;
                timer_d = '0;
            end
        endcase
    end

    // A simultaneous admission and departure cancel out; the count saturates
    // at both ends so stray sensor pulses cannot corrupt it.
    always_comb begin
        decCount = bus.car_out && (count_q != '0);
        incCount = openExit && ((count_q != CAP_V) || decCount);
        count_d  = count_q;
        if (incCount && !decCount) begin
            count_d = count_q + CNT_W'(1);
        end else if (decCount && !incCount) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign bus.green_led = (state_q == OPEN);
    assign bus.gate_open = (state_q == OPEN);
    assign bus.locked    = (state_q == LOCK);
    assign bus.red_led   = (state_q == WRONG) || (state_q == LOCK) ||
                           ((state_q == IDLE) && fullNow);
    assign bus.full      = fullNow;
    assign bus.count     = count_q;
endmodule

// File: doc/parking_ctrl.md
PARKING_CTRL -- requirements
Module: parking_ctrl

Interface
REQ-001 Parameter CAPACITY, default 8, maximum number of parked cars, 1 to 255.
REQ-002 Parameter PW_W, default 4, password width in bits.
REQ-003 Parameter PASSWORD, default 4'hA, the accepted password value, PW_W bits.
REQ-004 Parameter MAX_TRIES, default 3, wrong entries per car that trigger lockout, minimum 1.
REQ-005 Parameter GATE_CYCLES, default 8, number of cycles the gate stays open, minimum 1.
REQ-006 Parameter LOCK_CYCLES, default 16, lockout duration in cycles, minimum 1.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  system clock; all state updates on its rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 car_in  input  1  entry sensor; 1 = car detected at the gate.
REQ-011 car_out  input  1  exit sensor; single-cycle pulse per departing car.
REQ-012 pw_valid  input  1  strobe; pw_data is sampled on this cycle.
REQ-013 pw_data  input  PW_W  entered password.
REQ-014 green_led  output  1  access granted.
REQ-015 red_led  output  1  wrong password, lockout, or lot full.
REQ-016 gate_open  output  1  gate actuator.
REQ-017 locked  output  1  lockout active.
REQ-018 full  output  1  count equals CAPACITY.
REQ-019 count  output  $clog2(CAPACITY+1)  number of cars currently parked.

Function
REQ-020 The FSM shall have five states: IDLE, WAIT_PW, WRONG, OPEN, LOCK; outputs are decoded from registered state, counters and count only (Moore).
REQ-021 IDLE: car_in=1 and full=0 -> WAIT_PW, with the try counter cleared.
REQ-022 IDLE: car_in=1 and full=1 -> stay in IDLE; red_led=1 while full=1 in IDLE.
REQ-023 WAIT_PW and WRONG, pw_valid=1 and pw_data==PASSWORD -> OPEN, with the gate timer loaded to GATE_CYCLES.
REQ-024 WAIT_PW and WRONG, pw_valid=1 and mismatch -> try counter increments; if the new value equals MAX_TRIES -> LOCK with the lock timer loaded to LOCK_CYCLES, else -> WRONG.
REQ-025 WAIT_PW and WRONG, pw_valid=0 -> hold state; car_in is ignored.
REQ-026 OPEN shall last exactly GATE_CYCLES cycles with green_led=1 and gate_open=1, then go to IDLE.
REQ-027 On the cycle OPEN exits, count increments by 1.
REQ-028 LOCK shall last exactly LOCK_CYCLES cycles with red_led=1 and locked=1, then go to IDLE with the try counter cleared.
REQ-029 In LOCK, car_in and pw_valid are ignored.
REQ-030 red_led=1 in WRONG and in LOCK.
REQ-031 green_led and red_led shall never be 1 in the same cycle; in OPEN, red_led=0 even when full=1.
REQ-032 car_out=1 with count>0 decrements count in any state; car_out with count=0 is ignored (no underflow).
REQ-033 An OPEN-exit increment and a car_out decrement in the same cycle leave count unchanged.
REQ-034 count shall never exceed CAPACITY; full = (count==CAPACITY), combinational from count.
REQ-035 Unreachable state encodings shall go to IDLE on the next clock.

Reset
REQ-036 reset=0 forces, asynchronously, state=IDLE, count=0, try counter=0, timers=0.
REQ-037 During reset all outputs are 0, including full (with CAPACITY>=1).
REQ-038 Reset asserted mid-OPEN or mid-LOCK aborts the state immediately; no count increment occurs.
REQ-039 The first state update occurs on the first rising clk edge after reset returns to 1.

Verification
REQ-040 Params CAPACITY=2, PASSWORD=4'hA, MAX_TRIES=3, GATE_CYCLES=4, LOCK_CYCLES=8 for all scenarios.
REQ-041 car_in=1, then pw_valid with 4'hA -> OPEN, green_led=gate_open=1 for exactly 4 cycles, then IDLE with count=1.
REQ-042 Car enters; send 4'h3, then 4'hA -> red_led=1 after the wrong entry, then OPEN, then count=1.
REQ-043 Car enters; three wrong passwords -> LOCK, red_led=locked=1 for exactly 8 cycles; pw_valid with 4'hA during LOCK is ignored; then IDLE with tries=0.
REQ-044 Two cars admitted (count=2, full=1); car_in -> stays IDLE with red_led=1; car_out pulse -> count=1, full=0.
REQ-045 car_out on the same cycle as OPEN exits -> count unchanged; car_out at count=0 -> count stays 0.
REQ-046 reset=0 asserted on the 2nd OPEN cycle -> immediate IDLE, all outputs 0, count=0.
